// File: rtl/scan_sel_sequencer_pkg.sv
// Shared types and constants for the scan select sequencer and its
// next-channel finder.
package scan_seq_pkg;

   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      BLANK = 2'd2
   } state_t;

endpackage

// File: rtl/scan_sel_sequencer_next_chan.sv
// Combinational finder: lowest enabled channel strictly above cur, else the
// lowest enabled channel overall (flagged as a wrap). cur=7 yields the lowest bit.
module scan_next_chan
   import scan_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   output logic [SEL_W-1:0]  nxt,
   output logic              wrapped,
   output logic              none
);

   logic [SEL_W-1:0] above;
   logic [SEL_W-1:0] lowest;
   logic             have_above;

   // NOTE: every variable is given a default before the loop so no path
   // leaves it unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      above      = '0;
      lowest     = '0;
      have_above = 1'b0;
      // Descending scan so the last hit is the lowest matching index.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            lowest = SEL_W'(i);
            if (SEL_W'(i) > cur) begin
               above      = SEL_W'(i);
               have_above = 1'b1;
            end
         end
      end
   end

   assign none    = (mask == '0);
   assign nxt     = have_above ? above : lowest;
   assign wrapped = !have_above && !none;

endmodule

// File: rtl/scan_sel_sequencer.sv
// Time-multiplexed select generator for a 3-to-8 decoder with registered
// sel/en outputs. Define SCAN_SEL_SEQUENCER_BLANK_EN for a one-cycle blank between channels.
module scan_sel_sequencer
   import scan_seq_pkg::*;
#(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [NUM_CH-1:0]  chan_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               en,
   output logic               busy,
   output logic               wrap
);

   state_t             state, state_nx;
   logic [SEL_W-1:0]   sel_nx;
   logic               en_nx, busy_nx, wrap_nx;
   logic [DWELL_W-1:0] cnt, cnt_nx;
   logic [DWELL_W-1:0] dwell_q, dwell_q_nx;

   logic [SEL_W-1:0]   search_cur;
   logic [SEL_W-1:0]   nxt;
   logic               wrapped, none;

   // From IDLE the search starts past the top so it returns the lowest set bit.
   assign search_cur = (state == IDLE) ? SEL_W'(NUM_CH - 1) : sel;

   scan_next_chan u_next_chan (
      .mask    (chan_mask),
      .cur     (search_cur),
      .nxt     (nxt),
      .wrapped (wrapped),
      .none    (none)
   );

   always_comb begin
      state_nx   = state;
      sel_nx     = sel;
      en_nx      = en;
      busy_nx    = busy;
      wrap_nx    = 1'b0;
      cnt_nx     = cnt;
      dwell_q_nx = dwell_q;

      if (stop) begin
         state_nx = IDLE;
         en_nx    = 1'b0;
         busy_nx  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               en_nx   = 1'b0;
               busy_nx = 1'b0;
               if (start && !none) begin
                  state_nx   = DWELL;
                  sel_nx     = nxt;
                  dwell_q_nx = dwell;
                  cnt_nx     = '0;
                  en_nx      = 1'b1;
                  busy_nx    = 1'b1;
               end
            end
            DWELL: begin
               if (cnt == dwell_q) begin
                  if (none) begin
                     state_nx = IDLE;
                     en_nx    = 1'b0;
                     busy_nx  = 1'b0;
                  end else begin
                     sel_nx  = nxt;
                     wrap_nx = wrapped;
`ifdef SCAN_SEL_SEQUENCER_BLANK_EN
                     state_nx = BLANK;
                     en_nx    = 1'b0;
`else
                     cnt_nx     = '0;
                     dwell_q_nx = dwell;
`endif
                  end
               end else begin
                  cnt_nx = cnt + DWELL_W'(1);
               end
            end
`ifdef SCAN_SEL_SEQUENCER_BLANK_EN
            BLANK: begin
               // Dead time is over; enter the already-selected channel.
               state_nx   = DWELL;
               en_nx      = 1'b1;
               cnt_nx     = '0;
               dwell_q_nx = dwell;
            end
`endif
            default: begin
               state_nx = IDLE;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel     <= '0;
         en      <= 1'b0;
         busy    <= 1'b0;
         wrap    <= 1'b0;
         cnt     <= '0;
         dwell_q <= '0;
      end else begin
         state   <= state_nx;
         sel     <= sel_nx;
         en      <= en_nx;
         busy    <= busy_nx;
         wrap    <= wrap_nx;
         cnt     <= cnt_nx;
         dwell_q <= dwell_q_nx;
      end
   end

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed self-checking bench for scan_sel_sequencer; expected sel/en/busy/wrap
// values are hand-derived per cycle. Checks sample 1 ns after each rising edge.
module tb_scan_sel_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [7:0]  chan_mask;
   logic [15:0] dwell;
   logic [2:0]  sel;
   logic        en, busy, wrap;

   int n_checks = 0;
   int n_errors = 0;

   scan_sel_sequencer #(.DWELL_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .chan_mask (chan_mask),
      .dwell     (dwell),
      .sel       (sel),
      .en        (en),
      .busy      (busy),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   // Compares {sel,en,busy,wrap} against the expected tuple.
   task automatic check(input string tag, input logic [2:0] e_sel, input logic e_en,
                        input logic e_busy, input logic e_wrap);
      logic [5:0] got, exp;
      got = {sel, en, busy, wrap};
      exp = {e_sel, e_en, e_busy, e_wrap};
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got sel=%0d en=%b busy=%b wrap=%b, expected sel=%0d en=%b busy=%b wrap=%b",
                  tag, sel, en, busy, wrap, e_sel, e_en, e_busy, e_wrap);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; chan_mask = '0; dwell = '0;
      step();
      step();
      check("reset", 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      check("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef SCAN_SEL_SEQUENCER_BLANK_EN
      begin
         int bsel[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
         bit ben[9]   = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
         bit bwrap[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
         chan_mask = 8'h03; dwell = 16'd1;
         pulse_start();
         for (int i = 0; i < 9; i++) begin
            check($sformatf("blank_%0d", i), 3'(bsel[i]), ben[i], 1'b1, bwrap[i]);
            if (i < 8) step();
         end
         pulse_stop();
         check("stop_in_blank", 3'd1, 1'b0, 1'b0, 1'b0);

         // Mask cleared at the advance: straight to IDLE, no BLANK cycle.
         chan_mask = 8'h04; dwell = 16'd0;
         pulse_start();
         check("blank_m0_enter", 3'd2, 1'b1, 1'b1, 1'b0);
         chan_mask = 8'h00;
         step();
         check("blank_m0_idle", 3'd2, 1'b0, 1'b0, 1'b0);
      end
`else
      // Full mask, dwell=2: 3 cycles per channel, wrap on the return to 0.
      chan_mask = 8'hFF; dwell = 16'd2;
      pulse_start();
      for (int ch = 0; ch < 8; ch++) begin
         for (int c = 0; c < 3; c++) begin
            check($sformatf("ff_ch%0d_c%0d", ch, c), 3'(ch), 1'b1, 1'b1, 1'b0);
            step();
         end
      end
      check("ff_wrap", 3'd0, 1'b1, 1'b1, 1'b1);
      step();
      check("ff_wrap_drop", 3'd0, 1'b1, 1'b1, 1'b0);
      pulse_stop();
      check("ff_stop", 3'd0, 1'b0, 1'b0, 1'b0);

      // Sparse mask, dwell=0: 2,5,7,2,5 one cycle each.
      begin
         int sq[5]  = '{2, 5, 7, 2, 5};
         bit wq[5]  = '{0, 0, 0, 1, 0};
         chan_mask = 8'b1010_0100; dwell = 16'd0;
         pulse_start();
         for (int i = 0; i < 5; i++) begin
            check($sformatf("sparse_%0d", i), 3'(sq[i]), 1'b1, 1'b1, wq[i]);
            step();
         end
         pulse_stop();
         check("sparse_stop_hold_sel", 3'd7, 1'b0, 1'b0, 1'b0);
      end

      // Empty mask start is ignored; single channel wraps every period.
      chan_mask = 8'h00; dwell = 16'd1;
      pulse_start();
      check("mask0_start", 3'd7, 1'b0, 1'b0, 1'b0);
      step();
      check("mask0_still_idle", 3'd7, 1'b0, 1'b0, 1'b0);
      begin
         bit wq[6] = '{0, 0, 1, 0, 1, 0};
         chan_mask = 8'h10;
         pulse_start();
         for (int i = 0; i < 6; i++) begin
            check($sformatf("single_%0d", i), 3'd4, 1'b1, 1'b1, wq[i]);
            step();
         end
      end
      pulse_stop();
      check("single_stop", 3'd4, 1'b0, 1'b0, 1'b0);

      // Stop mid-dwell on channel 3, then start+stop together while busy.
      chan_mask = 8'h48; dwell = 16'd3;
      pulse_start();
      check("ch3_enter", 3'd3, 1'b1, 1'b1, 1'b0);
      step();
      pulse_stop();
      check("ch3_stop", 3'd3, 1'b0, 1'b0, 1'b0);
      pulse_start();
      check("ch3_restart", 3'd3, 1'b1, 1'b1, 1'b0);
      step(); step(); step(); step();
      check("ch6_advance", 3'd6, 1'b1, 1'b1, 1'b0);
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check("start_stop_same", 3'd6, 1'b0, 1'b0, 1'b0);
      pulse_start();
      check("resume_lowest", 3'd3, 1'b1, 1'b1, 1'b0);
      pulse_stop();

      // Mask cleared mid-dwell: channel 6 still gets its 5 cycles.
      chan_mask = 8'h40; dwell = 16'd4;
      pulse_start();
      for (int c = 0; c < 5; c++) begin
         check($sformatf("clr_ch6_c%0d", c), 3'd6, 1'b1, 1'b1, 1'b0);
         if (c == 2) chan_mask = 8'h00;
         step();
      end
      check("clr_idle", 3'd6, 1'b0, 1'b0, 1'b0);

      // Reset mid-scan clears sel as well.
      chan_mask = 8'hFF; dwell = 16'd2;
      pulse_start();
      step(); step(); step();
      check("pre_rst", 3'd1, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      check("rst_midscan", 3'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
